// File: rtl/seven_segments.sv
// Four-digit multiplexed seven-segment driver: clamps a 16-bit value to 9999,
// converts it with a free-running double-dabble engine and scans it onto active-low pins.
module seven_segments #(
   parameter int REFRESH_CYCLES = 2000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [15:0] bin_i,
   output logic [3:0]  anodo_o,
   output logic [6:0]  catodo_o
);

   localparam logic [1:0] ST_LOAD  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);

   logic [1:0]       state_q, state_d;
   logic [3:0]       step_q, step_d;
   logic [15:0]      bin_sr_q, bin_sr_d;
   logic [15:0]      bcd_q, bcd_d;
   logic [15:0]      digit_q, digit_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic [3:0]       anodo_q, anodo_d;
   logic [6:0]       catodo_q, catodo_d;
   logic [3:0]       cur_digit_s;
   logic             blank_s;
   logic [31:0]      dabbled_s;

   // One add-3-then-shift step over the {bcd, binary} pair.
   function automatic logic [31:0] dabble(input logic [31:0] v);
      logic [31:0] t;
      t = v;
      for (int n = 0; n < 4; n++) begin
         if (t[16 + 4*n +: 4] >= 4'd5) begin
            t[16 + 4*n +: 4] = t[16 + 4*n +: 4] + 4'd3;
         end else begin
            t[16 + 4*n +: 4] = t[16 + 4*n +: 4];
         end
      end
      return {t[30:0], 1'b0};
   endfunction

   function automatic logic [6:0] seg(input logic [3:0] d);
      case (d)
         4'd0:    seg = 7'b1000000;
         4'd1:    seg = 7'b1111001;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         default: seg = 7'b1111111;
      endcase
   endfunction

   assign dabbled_s = dabble({bcd_q, bin_sr_q});

   // Converter: LOAD (1) -> SHIFT (16) -> DONE (1), free-running.
   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      bin_sr_d = bin_sr_q;
      bcd_d    = bcd_q;
      digit_d  = digit_q;
      case (state_q)
         ST_LOAD: begin
            bin_sr_d = (bin_i > 16'd9999) ? 16'd9999 : bin_i;
            bcd_d    = 16'd0;
            step_d   = 4'd0;
            state_d  = ST_SHIFT;
         end
         ST_SHIFT: begin
            {bcd_d, bin_sr_d} = dabbled_s;
            step_d = step_q + 4'd1;
            if (step_q == 4'd15) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_SHIFT;
            end
         end
         ST_DONE: begin
            digit_d = bcd_q;
            state_d = ST_LOAD;
         end
         default: state_d = ST_LOAD;
      endcase
   end

   // Scan: refresh counter, digit index and the registered pin values.
   always_comb begin
      if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         idx_d = idx_q + 2'd1;
      end else begin
         cnt_d = cnt_q + CNT_W'(1'b1);
         idx_d = idx_q;
      end
      case (idx_q)
         2'd3:    begin cur_digit_s = digit_q[15:12]; blank_s = (digit_q[15:12] == 4'd0); end
         2'd2:    begin cur_digit_s = digit_q[11:8];  blank_s = (digit_q[15:8]  == 8'd0); end
         2'd1:    begin cur_digit_s = digit_q[7:4];   blank_s = (digit_q[15:4]  == 12'd0); end
         default: begin cur_digit_s = digit_q[3:0];   blank_s = 1'b0; end
      endcase
      anodo_d  = ~(4'b0001 << idx_q);
      catodo_d = blank_s ? 7'b1111111 : seg(cur_digit_s);
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= ST_LOAD;
         step_q   <= 4'd0;
         bin_sr_q <= 16'd0;
         bcd_q    <= 16'd0;
         digit_q  <= 16'd0;
         cnt_q    <= '0;
         idx_q    <= 2'd0;
         anodo_q  <= 4'b1111;
         catodo_q <= 7'b1111111;
      end else begin
         state_q  <= state_d;
         step_q   <= step_d;
         bin_sr_q <= bin_sr_d;
         bcd_q    <= bcd_d;
         digit_q  <= digit_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         anodo_q  <= anodo_d;
         catodo_q <= catodo_d;
      end
   end

   assign anodo_o  = anodo_q;
   assign catodo_o = catodo_q;

endmodule

// File: tb/tb_seven_segments.sv
// Self-checking bench for seven_segments: a decimal-arithmetic display model
// predicts the pins every cycle; scenario tasks compare against it.
module tb_seven_segments;

   localparam int R = 2000;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [15:0] bin_i;
   logic [3:0]  anodo_o;
   logic [6:0]  catodo_o;

   int n_cmp = 0;
   int n_bad = 0;

   logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

   always #5 clk_i = ~clk_i;

   seven_segments #(.REFRESH_CYCLES(R)) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .bin_i    (bin_i),
      .anodo_o  (anodo_o),
      .catodo_o (catodo_o)
   );

   function automatic int clamp(input int v);
      return (v > 9999) ? 9999 : v;
   endfunction

   function automatic logic [6:0] ref_cat(input int v, input int pos);
      int p10 = 1;
      for (int i = 0; i < pos; i++) p10 = p10 * 10;
      if (pos > 0 && v < p10) return 7'b1111111;
      return seg_tab[(v / p10) % 10];
   endfunction

   // Reference: m_t counts edges since release; sampling every 18 edges, publishing 17 later.
   int         m_t, m_samp, m_disp;
   logic [3:0] exp_an;
   logic [6:0] exp_cat;
   always @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         m_t <= 0; m_samp <= 0; m_disp <= 0;
         exp_an <= 4'b1111; exp_cat <= 7'b1111111;
      end else begin
         exp_an  <= ~(4'b0001 << ((m_t / R) % 4));
         exp_cat <= ref_cat(m_disp, (m_t / R) % 4);
         if (m_t % 18 == 0) m_samp <= clamp(int'(bin_i));
         if ((m_t + 1) % 18 == 0) m_disp <= m_samp;
         m_t <= m_t + 1;
      end
   end

   task automatic test_reset();
      rst_i = 1'b0;
      bin_i = 16'd1234;
      repeat (3) @(negedge clk_i);
      n_cmp++;
      if (anodo_o !== 4'b1111 || catodo_o !== 7'b1111111) begin
         n_bad++;
         $display("FAIL reset_blank anodo=%b catodo=%b want 1111/1111111", anodo_o, catodo_o);
      end
      rst_i = 1'b1;
      @(negedge clk_i);
      n_cmp++;
      if (anodo_o !== 4'b1110 || catodo_o !== 7'b1000000) begin
         n_bad++;
         $display("FAIL reset_first_edge anodo=%b catodo=%b want 1110/1000000", anodo_o, catodo_o);
      end
   endtask

   task automatic test_bcd_1234();
      logic [3:0] prev = anodo_o;
      int run = 1;
      for (int i = 0; i < 10000; i++) begin
         @(negedge clk_i);
         n_cmp++;
         if (anodo_o !== exp_an || catodo_o !== exp_cat) begin
            n_bad++;
            $display("FAIL bcd_1234 cyc=%0d anodo=%b want %b catodo=%b want %b",
                     i, anodo_o, exp_an, catodo_o, exp_cat);
         end
         if (anodo_o !== prev) begin
            n_cmp++;
            if (run != R) begin
               n_bad++;
               $display("FAIL digit_hold anodo=%b held %0d want %0d", prev, run, R);
            end
            prev = anodo_o;
            run  = 1;
         end else begin
            run++;
         end
      end
   endtask

   task automatic test_latency_5678();
      @(negedge clk_i);
      bin_i = 16'd5678;
      for (int i = 0; i < 8100; i++) begin
         @(negedge clk_i);
         n_cmp++;
         if (anodo_o !== exp_an || catodo_o !== exp_cat) begin
            n_bad++;
            $display("FAIL latency_5678 cyc=%0d anodo=%b want %b catodo=%b want %b",
                     i, anodo_o, exp_an, catodo_o, exp_cat);
         end
      end
   endtask

   task automatic test_clamp();
      int vals [2] = '{9999, 40000};
      for (int k = 0; k < 2; k++) begin
         bin_i = 16'(vals[k]);
         for (int i = 0; i < 8100; i++) begin
            @(negedge clk_i);
            n_cmp++;
            if (anodo_o !== exp_an || catodo_o !== exp_cat) begin
               n_bad++;
               $display("FAIL clamp_%0d cyc=%0d anodo=%b want %b catodo=%b want %b",
                        vals[k], i, anodo_o, exp_an, catodo_o, exp_cat);
            end
         end
         n_cmp++;
         if (catodo_o !== 7'b0010000) begin
            n_bad++;
            $display("FAIL clamp_nine_%0d catodo=%b want 0010000", vals[k], catodo_o);
         end
      end
   endtask

   task automatic test_blanking();
      int vals [2] = '{0, 7};
      for (int k = 0; k < 2; k++) begin
         bin_i = 16'(vals[k]);
         for (int i = 0; i < 8100; i++) begin
            @(negedge clk_i);
            n_cmp++;
            if (anodo_o !== exp_an || catodo_o !== exp_cat) begin
               n_bad++;
               $display("FAIL blank_%0d cyc=%0d anodo=%b want %b catodo=%b want %b",
                        vals[k], i, anodo_o, exp_an, catodo_o, exp_cat);
            end
         end
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 2; k++) begin
         bin_i = (k == 0) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(10, 999));
         for (int i = 0; i < 8100; i++) begin
            @(negedge clk_i);
            if (i % 7 == 3) bin_i = bin_i ^ 16'($urandom_range(0, 3));
            n_cmp++;
            if (anodo_o !== exp_an || catodo_o !== exp_cat) begin
               n_bad++;
               $display("FAIL random_%0d cyc=%0d bin=%0d anodo=%b want %b catodo=%b want %b",
                        k, i, bin_i, anodo_o, exp_an, catodo_o, exp_cat);
            end
         end
      end
   endtask

   task automatic test_midrun_reset();
      int guard = 0;
      bin_i = 16'd4321;
      while (!(m_t % 18 == 5 && m_t % R > 100 && m_t % R < R - 100) && guard < 5000) begin
         @(posedge clk_i);
         guard++;
      end
      n_cmp++;
      if (guard >= 5000) begin
         n_bad++;
         $display("FAIL midrun_wait timed out after %0d cycles, want < 5000", guard);
      end
      #2 rst_i = 1'b0;
      #1;
      n_cmp++;
      if (anodo_o !== 4'b1111 || catodo_o !== 7'b1111111) begin
         n_bad++;
         $display("FAIL midrun_async_blank anodo=%b catodo=%b want 1111/1111111", anodo_o, catodo_o);
      end
      repeat (2) @(negedge clk_i);
      rst_i = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk_i);
         n_cmp++;
         if (anodo_o !== exp_an || catodo_o !== exp_cat) begin
            n_bad++;
            $display("FAIL midrun_resume cyc=%0d anodo=%b want %b catodo=%b want %b",
                     i, anodo_o, exp_an, catodo_o, exp_cat);
         end
      end
      n_cmp++;
      if (catodo_o !== 7'b1111001) begin
         n_bad++;
         $display("FAIL midrun_units catodo=%b want 1111001", catodo_o);
      end
   endtask

   initial begin
      test_reset();
      test_bcd_1234();
      test_latency_5678();
      test_clamp();
      test_blanking();
      test_random();
      test_midrun_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
